// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline boundary of p_cpu:
// FSM state encoding, the opcodes the hazard logic needs, and the
// helper that decides whether an instruction reads rt as a source.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [5:0] OP_ALUOP = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type ALU ops, branches and stores read rt; everything else
  // (immediates, loads, jumps) uses rt as a destination or not at all.
  function automatic logic op_uses_rt(input logic [5:0] op);
    case (op)
      OP_ALUOP, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between the fetch/execute side of the pipeline (master) and the
// IF/ID boundary register (slave). Clock and reset stay plain ports.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      if_inst;
  logic [31:0]      if_pc4;
  logic             ctrl_branch;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;

  logic [31:0]      id_inst;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic             if_wpcir;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_inst, if_pc4, ctrl_branch, ex_mem_read, ex_rt,
    input  id_inst, id_pc4, id_valid, if_wpcir, ex_bubble,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  if_inst, if_pc4, ctrl_branch, ex_mem_read, ex_rt,
    output id_inst, id_pc4, id_valid, if_wpcir, ex_bubble,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/if_id_stage_hazard_unit.sv
// Load-use hazard detection between the instruction held in ID and a
// load sitting in EX. Purely combinational so a later forwarding unit
// can reuse it unchanged.
module hazard_unit
  import if_id_stage_pkg::*;
(
  input  logic       enable,
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hz
);

  logic uses_rt;
  logic rs_match;
  logic rt_match;

  assign uses_rt  = op_uses_rt(id_op);
  assign rs_match = (ex_rt == id_rs);
  assign rt_match = uses_rt && (ex_rt == id_rt);

  // A load into $zero never produces a real value, so it cannot create a hazard.
  assign hz = enable && id_valid && ex_mem_read && (ex_rt != 5'd0) &&
              (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register of p_cpu. Captures the fetched instruction and
// PC+1, stalls fetch on load-use hazards, squashes on branch/jump
// resolution in ID, and requests a bubble in EX while stalled.
// Optional build macro IFID_PERF_EN adds saturating stall/flush counters;
// without it the counter outputs are tied to zero.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  if_id_stage_if.slave bus
);

  state_e      state;
  logic [31:0] id_inst_q;
  logic [31:0] id_pc4_q;
  logic        id_valid_q;
  logic        hz;
  logic        active;
  logic        flush_evt;

  assign active = (state != ST_BOOT);

  hazard_unit u_hazard (
    .enable      (active),
    .id_valid    (id_valid_q),
    .id_op       (id_inst_q[31:26]),
    .id_rs       (id_inst_q[25:21]),
    .id_rt       (id_inst_q[20:16]),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .hz          (hz)
  );

  // A stalled branch has not resolved yet, so the stall outranks the flush.
  assign flush_evt = active && !hz && bus.ctrl_branch;

  // FSM and IF/ID registers: hold on hazard, squash on branch, else capture.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BOOT;
      id_inst_q  <= NOP_INST;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        default: begin
          state <= hz ? ST_STALL : ST_RUN;
          if (hz) begin
            id_inst_q  <= id_inst_q;
            id_pc4_q   <= id_pc4_q;
            id_valid_q <= id_valid_q;
          end else if (bus.ctrl_branch) begin
            id_inst_q  <= NOP_INST;
            id_pc4_q   <= bus.if_pc4;
            id_valid_q <= 1'b0;
          end else begin
            id_inst_q  <= bus.if_inst;
            id_pc4_q   <= bus.if_pc4;
            id_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.if_wpcir  = hz;
  assign bus.ex_bubble = hz;

`ifdef IFID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters: stall cycles and branch flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush  = flush_evt;
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset/boot, a table of single-cycle
// vectors (capture, load-use stall, $zero and non-rt cases, flush, stall
// priority, back-to-back stall), reset during a stall and counter saturation.
module tb_if_id_stage;

  localparam int CW = 4;
`ifdef IFID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  if_id_stage_if #(.CNT_W(CW)) bus ();

  if_id_stage #(.NOP_INST(32'h0000_0000), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        br;
    logic        mr;
    logic [4:0]  rt;
    logic        x_hz;
    logic [31:0] x_inst;
    logic [31:0] x_pc4;
    logic        x_valid;
    int          x_scnt;
    int          x_fcnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc4,
                       input logic br, input logic mr, input logic [4:0] rt);
    bus.if_inst     = inst;
    bus.if_pc4      = pc4;
    bus.ctrl_branch = br;
    bus.ex_mem_read = mr;
    bus.ex_rt       = rt;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.inst, v.pc4, v.br, v.mr, v.rt);
    #1;
    check($sformatf("v%0d.if_wpcir", idx), {31'd0, bus.if_wpcir}, {31'd0, v.x_hz});
    check($sformatf("v%0d.ex_bubble", idx), {31'd0, bus.ex_bubble}, {31'd0, v.x_hz});
    @(posedge clk);
    #1;
    check($sformatf("v%0d.id_inst", idx), bus.id_inst, v.x_inst);
    check($sformatf("v%0d.id_pc4", idx), bus.id_pc4, v.x_pc4);
    check($sformatf("v%0d.id_valid", idx), {31'd0, bus.id_valid}, {31'd0, v.x_valid});
    check($sformatf("v%0d.stall_cnt", idx), 32'(bus.stall_cnt), cnt_exp(v.x_scnt));
    check($sformatf("v%0d.flush_cnt", idx), 32'(bus.flush_cnt), cnt_exp(v.x_fcnt));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    //           inst          pc4  br  mr  rt  hz  exp_inst      pc4  vld scnt fcnt
    vecs[0]  = '{32'h00221820, 32'd2,  1'b0, 1'b0, 5'd0, 1'b0, 32'h00221820, 32'd2,  1'b1, 0, 0};
    vecs[1]  = '{32'h00851020, 32'd3,  1'b0, 1'b1, 5'd1, 1'b1, 32'h00221820, 32'd2,  1'b1, 1, 0};
    vecs[2]  = '{32'h00851020, 32'd3,  1'b0, 1'b0, 5'd1, 1'b0, 32'h00851020, 32'd3,  1'b1, 1, 0};
    vecs[3]  = '{32'h00001820, 32'd4,  1'b0, 1'b0, 5'd0, 1'b0, 32'h00001820, 32'd4,  1'b1, 1, 0};
    vecs[4]  = '{32'h8C220000, 32'd5,  1'b0, 1'b1, 5'd0, 1'b0, 32'h8C220000, 32'd5,  1'b1, 1, 0};
    vecs[5]  = '{32'hAC430004, 32'd6,  1'b0, 1'b1, 5'd2, 1'b0, 32'hAC430004, 32'd6,  1'b1, 1, 0};
    vecs[6]  = '{32'h12345678, 32'd7,  1'b0, 1'b1, 5'd3, 1'b1, 32'hAC430004, 32'd6,  1'b1, 2, 0};
    vecs[7]  = '{32'h00851020, 32'd8,  1'b1, 1'b0, 5'd3, 1'b0, 32'h00000000, 32'd8,  1'b0, 2, 1};
    vecs[8]  = '{32'h00221820, 32'd9,  1'b0, 1'b0, 5'd0, 1'b0, 32'h00221820, 32'd9,  1'b1, 2, 1};
    vecs[9]  = '{32'h00851020, 32'd12, 1'b1, 1'b1, 5'd2, 1'b1, 32'h00221820, 32'd9,  1'b1, 3, 1};
    vecs[10] = '{32'h00851020, 32'd12, 1'b0, 1'b1, 5'd1, 1'b1, 32'h00221820, 32'd9,  1'b1, 4, 1};
    vecs[11] = '{32'h00221820, 32'd10, 1'b0, 1'b0, 5'd1, 1'b0, 32'h00221820, 32'd10, 1'b1, 4, 1};

    // Reset, then one BOOT cycle before the first capture.
    rst = 1'b0;
    drive(32'h20010005, 32'd1, 1'b0, 1'b0, 5'd0);
    #1;
    check("rst.id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst.id_inst", bus.id_inst, 32'h0);
    check("rst.id_pc4", bus.id_pc4, 32'h0);
    check("rst.if_wpcir", {31'd0, bus.if_wpcir}, 32'd0);
    check("rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("boot.id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("boot.id_inst", bus.id_inst, 32'h0);
    @(posedge clk);
    #1;
    check("cap1.id_inst", bus.id_inst, 32'h20010005);
    check("cap1.id_pc4", bus.id_pc4, 32'd1);
    check("cap1.id_valid", {31'd0, bus.id_valid}, 32'd1);

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(32'h00851020, 32'd11, 1'b0, 1'b1, 5'd1);
    #1;
    check("pre_rst.if_wpcir", {31'd0, bus.if_wpcir}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst.id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("mid_rst.if_wpcir", {31'd0, bus.if_wpcir}, 32'd0);
    check("mid_rst.ex_bubble", {31'd0, bus.ex_bubble}, 32'd0);
    check("mid_rst.id_inst", bus.id_inst, 32'h0);
    check("mid_rst.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("mid_rst.flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // Counter saturation: 20 consecutive stall cycles on a 4-bit counter.
    @(negedge clk);
    rst = 1'b1;
    drive(32'h00221820, 32'd11, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("sat.capture", bus.id_inst, 32'h00221820);
    @(negedge clk);
    drive(32'h00851020, 32'd12, 1'b0, 1'b1, 5'd1);
    repeat (20) @(posedge clk);
    #1;
    check("sat.stall_cnt", 32'(bus.stall_cnt), cnt_exp(15));
    check("sat.flush_cnt", 32'(bus.flush_cnt), 32'd0);
    check("sat.if_wpcir", {31'd0, bus.if_wpcir}, 32'd1);
    check("sat.id_inst", bus.id_inst, 32'h00221820);
    @(negedge clk);
    drive(32'h00851020, 32'd12, 1'b0, 1'b0, 5'd1);
    @(posedge clk);
    #1;
    check("resume.id_inst", bus.id_inst, 32'h00851020);
    check("resume.stall_cnt", 32'(bus.stall_cnt), cnt_exp(15));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline boundary of the p_cpu pipeline. Sits between the fetch stage and the decode stage.
- Captures the fetched instruction and its PC+1 each cycle.
- Detects load-use hazards against the instruction in EX and drives the fetch-stall signal (if_wpcir) back to fetch.
- Squashes the captured instruction when a branch or jump resolves in ID. Provides a valid bit and an EX-bubble request downstream.

Parameters:
- NOP_INST, 32'h00000000, instruction word loaded into id_inst on reset, flush or bubble.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_inst  in  32  instruction word from fetch.
- if_pc4  in  32  sequential next PC from fetch.
- ctrl_branch  in  1  branch/jump taken, resolved in ID; flush request.
- ex_mem_read  in  1  instruction currently in EX is LW.
- ex_rt  in  5  destination register of the instruction in EX.
- id_inst  out  32  registered instruction for decode.
- id_pc4  out  32  registered PC+1 for decode.
- id_valid  out  1  id_inst is a real instruction.
- if_wpcir  out  1  stall fetch and hold IF/ID (combinational).
- ex_bubble  out  1  ID/EX must load a bubble this cycle (combinational).
- stall_cnt  out  CNT_W  load-use stall cycle count.
- flush_cnt  out  CNT_W  flush event count.

Behaviour:
- Reset (rst=0, asynchronous):
  - id_inst=NOP_INST, id_pc4=0, id_valid=0.
  - stall_cnt=0, flush_cnt=0.
  - FSM=BOOT.
  - if_wpcir=0 and ex_bubble=0 while in BOOT.
- FSM states:
  - BOOT: one cycle after reset release. The registers capture nothing; id_valid stays 0. Always goes to RUN.
  - RUN: normal capture.
  - STALL: a load-use hazard is active.
  - RUN->STALL when hz=1. STALL->RUN when hz=0. STALL->STALL while hz=1.
- Field definitions: id_rs=id_inst[25:21], id_rt=id_inst[20:16], op=id_inst[31:26].
- uses_rt=1 for op in {OP_ALUOp, OP_BEQ, OP_BNE, OP_SW}; 0 otherwise.
- Hazard term: hz = id_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)).
- Combinational outputs: if_wpcir = hz; ex_bubble = hz.
- Register update at each rising clk, in priority order (state not BOOT):
  1. hz=1: hold id_inst, id_pc4 and id_valid. ctrl_branch is ignored, because a stalled branch has not resolved.
  2. ctrl_branch=1: id_inst=NOP_INST, id_valid=0. id_pc4 still loads if_pc4 (don't-care value).
  3. Otherwise: id_inst=if_inst, id_pc4=if_pc4, id_valid=1.
- Latency: exactly 1 cycle from the if_inst/if_pc4 sample to the id_* outputs.
- A load-use stall is normally exactly 1 cycle. Back-to-back stalls are legal if EX holds a further LW hazard.
- Counters (when enabled):
  - stall_cnt increments on every cycle with hz=1.
  - flush_cnt increments on every cycle where priority-2 applies.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-stall returns immediately to BOOT with all outputs at reset values.

Optional Feature:
- Macro: IFID_PERF_EN.
- Defined: stall_cnt and flush_cnt are implemented as above.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0. Pipeline behaviour is otherwise identical.

Decomposition:
- Shared macro header macro.vh holds OP_ALUOp=6'b000000, OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_SW=6'b101011 and OP_LW=6'b100011.
- Sub-module hazard_unit (combinational hz/uses_rt) makes the hazard logic reusable by a later forwarding unit. The FSM and registers stay in if_id_stage.

Test Plan:
- Reset release, if_inst=32'h20010005 every cycle:
  - Cycle 1 (BOOT): id_valid=0.
  - Cycle 2: id_inst=32'h20010005, id_valid=1.
- Load-use stall:
  - Setup: id_inst=32'h00221820 (add $3,$1,$2), ex_mem_read=1, ex_rt=1.
  - Expect: if_wpcir=1 and ex_bubble=1 in the same cycle; id_inst unchanged next edge; stall_cnt=1.
  - Then drop ex_mem_read: capture resumes.
- No hazard on $zero: ex_rt=0, ex_mem_read=1, id_rs=0 -> if_wpcir=0.
- No hazard from a non-rt-user: id_inst=LW 32'h8C220000 (rt=2, not a source), ex_rt=2 -> if_wpcir=0.
- Flush: ctrl_branch=1, if_inst=32'h00851020 -> next edge id_inst=0, id_valid=0, flush_cnt=1.
- Stall priority: ctrl_branch=1 with hz=1 simultaneously -> id_inst held, flush_cnt unchanged.
- Reset during STALL: rst=0 asynchronously -> id_valid=0 and if_wpcir=0 immediately, with no clock edge.
- Counter saturation: with CNT_W=4, 20 stall cycles -> stall_cnt=4'hF.
